// File: rtl/alarm_scheduler.sv
// Alarm scheduler: programmable alarm time, ring / snooze / auto-stop FSM.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   tick_1s           one-clock pulse per second from the time-of-day counter
//   cur_hour/minute/second  current time of day (binary)
//   alarm_arm         level, 1 = alarm enabled
//   set_hour/minute   one-clock pulses that advance the programmed alarm time
//   snooze, stop      one-clock button pulses
//   alarm_hour/minute programmed alarm time
//   buzzer            buzzer drive
//   ringing/snoozing  1 while in RING / SNOOZE
//   snooze_count      snoozes used in the current alarm event
//
// Build option: define ALARM_BEEP_EN for a 1 s on / 1 s off buzzer pattern
// while ringing; otherwise the buzzer is a steady tone equal to ringing.
module alarm_scheduler #(
  parameter int unsigned SNOOZE_MIN       = 9,
  parameter int unsigned RING_TIMEOUT_MIN = 5,
  parameter int unsigned MAX_SNOOZES      = 3,
  parameter int unsigned RESET_ALARM_HOUR = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  input  logic       alarm_arm,
  input  logic       set_hour,
  input  logic       set_minute,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_minute,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_count
);

  localparam int unsigned TIMER_W = 11;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned MIN_W   = 6;

  localparam logic [TIMER_W-1:0] RING_LOAD   = TIMER_W'(RING_TIMEOUT_MIN * 60);
  localparam logic [TIMER_W-1:0] SNOOZE_LOAD = TIMER_W'(SNOOZE_MIN * 60);
  localparam logic [CNT_W-1:0]   MAX_CNT     = CNT_W'(MAX_SNOOZES);
  localparam logic [HOUR_W-1:0]  RST_HOUR    = HOUR_W'(RESET_ALARM_HOUR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [HOUR_W-1:0]  hour_d;
  logic [MIN_W-1:0]   minute_d;
  logic [TIMER_W-1:0] ring_tmr_q, ring_tmr_d;
  logic [TIMER_W-1:0] snz_tmr_q, snz_tmr_d;
  logic [CNT_W-1:0]   count_d;
  logic               buzzer_d;
  logic               match;

  assign match = alarm_arm & tick_1s & (cur_hour == alarm_hour) &
                 (cur_minute == alarm_minute) & (cur_second == 6'd0);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alarm_hour   <= RST_HOUR;
      alarm_minute <= '0;
      ring_tmr_q   <= '0;
      snz_tmr_q    <= '0;
      snooze_count <= '0;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_hour   <= hour_d;
      alarm_minute <= minute_d;
      ring_tmr_q   <= ring_tmr_d;
      snz_tmr_q    <= snz_tmr_d;
      snooze_count <= count_d;
      buzzer       <= buzzer_d;
      ringing      <= (state_d == RING);
      snoozing     <= (state_d == SNOOZE);
    end
  end

  // Next-state logic; priority: disarm > stop > snooze > timer expiry > match
  always_comb begin
    state_d    = state_q;
    hour_d     = alarm_hour;
    minute_d   = alarm_minute;
    ring_tmr_d = ring_tmr_q;
    snz_tmr_d  = snz_tmr_q;
    count_d    = snooze_count;
    buzzer_d   = 1'b0;

    // Time setting is independent of the FSM; minute wrap does not carry
    if (set_hour)
      hour_d = (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
    if (set_minute)
      minute_d = (alarm_minute == 6'd59) ? 6'd0 : alarm_minute + 6'd1;

    if (!alarm_arm) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match) begin
            state_d    = RING;
            count_d    = '0;
            ring_tmr_d = RING_LOAD;
          end
        end
        RING: begin
          if (stop) begin
            state_d = IDLE;
            count_d = '0;
          end else if (snooze && (snooze_count < MAX_CNT)) begin
            state_d   = SNOOZE;
            count_d   = snooze_count + 3'd1;
            snz_tmr_d = SNOOZE_LOAD;
          end else if (tick_1s) begin
            // An ignored snooze falls through to the timer
            if (ring_tmr_q == 11'd1) begin
              state_d = IDLE;
              count_d = '0;
            end
            ring_tmr_d = ring_tmr_q - 11'd1;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = IDLE;
            count_d = '0;
          end else if (tick_1s) begin
            if (snz_tmr_q == 11'd1) begin
              state_d    = RING;
              ring_tmr_d = RING_LOAD;
            end
            snz_tmr_d = snz_tmr_q - 11'd1;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

`ifdef ALARM_BEEP_EN
    // Beep starts on at every RING entry, then toggles once per second
    if (state_d == RING) begin
      if (state_q != RING)
        buzzer_d = 1'b1;
      else if (tick_1s)
        buzzer_d = ~buzzer;
      else
        buzzer_d = buzzer;
    end
`else
    buzzer_d = (state_d == RING);
`endif
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler (default build, steady buzzer).
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1s;
  logic [4:0] cur_hour;
  logic [5:0] cur_minute;
  logic [5:0] cur_second;
  logic       alarm_arm;
  logic       set_hour;
  logic       set_minute;
  logic       snooze;
  logic       stop;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_minute;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [5:0] v;   // {ringing, snoozing, buzzer, snooze_count}
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alarm_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1s      (tick_1s),
    .cur_hour     (cur_hour),
    .cur_minute   (cur_minute),
    .cur_second   (cur_second),
    .alarm_arm    (alarm_arm),
    .set_hour     (set_hour),
    .set_minute   (set_minute),
    .snooze       (snooze),
    .stop         (stop),
    .alarm_hour   (alarm_hour),
    .alarm_minute (alarm_minute),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_count (snooze_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour   = 5'(h);
    cur_minute = 6'(m);
    cur_second = 6'(s);
  endtask

  // One clock with the currently driven inputs; pulses are cleared afterwards.
  task automatic cycle(input string tag, input logic r, input logic s, input logic [2:0] c);
    exp_t e;
    sb.push_back('{tag: tag, v: {r, s, r, c}});
    @(posedge clk);
    #1;
    tick_1s    = 1'b0;
    set_hour   = 1'b0;
    set_minute = 1'b0;
    snooze     = 1'b0;
    stop       = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, {26'd0, ringing, snoozing, buzzer, snooze_count}, {26'd0, e.v});
    end
  endtask

  // n seconds (tick then idle clock) with unchanged expected status
  task automatic tick_n(input int n, input string tag, input logic r, input logic s,
                        input logic [2:0] c);
    for (int i = 0; i < n; i++) begin
      tick_1s = 1'b1;
      cycle(tag, r, s, c);
      cycle(tag, r, s, c);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_status", {28'd0, ringing, snoozing, buzzer, snooze_count}, 32'd0);
    check("rst_hour", {27'd0, alarm_hour}, 32'd7);
    check("rst_min", {26'd0, alarm_minute}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic trigger();
    set_time(7, 0, 0);
    tick_1s = 1'b1;
    cycle("match_ring", 1'b1, 1'b0, 3'd0);
    set_time(7, 0, 30);
  endtask

  initial begin
    tick_1s = 0; set_hour = 0; set_minute = 0; snooze = 0; stop = 0;
    alarm_arm = 1'b1;
    set_time(6, 59, 59);
    rst_n = 1'b1;
    #3;
    do_reset();

    // Basic ring at 07:00:00
    tick_1s = 1'b1;
    cycle("pre_match", 1'b0, 1'b0, 3'd0);
    set_time(7, 0, 1);
    tick_1s = 1'b1;
    cycle("sec_nonzero", 1'b0, 1'b0, 3'd0);
    trigger();
    check("buzzer_on", {31'd0, buzzer}, 32'd1);

    // Snooze cycles: 540 s back to RING, up to MAX_SNOOZES
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      cycle("snooze", 1'b0, 1'b1, 3'(k));
      tick_n(539, "snz_wait", 1'b0, 1'b1, 3'(k));
      tick_1s = 1'b1;
      cycle("snz_expire", 1'b1, 1'b0, 3'(k));
    end
    snooze = 1'b1;
    cycle("snooze_max_ignored", 1'b1, 1'b0, 3'd3);
    tick_n(299, "ring_wait", 1'b1, 1'b0, 3'd3);
    tick_1s = 1'b1;
    cycle("auto_stop", 1'b0, 1'b0, 3'd0);

    // Snooze and stop in IDLE are ignored
    snooze = 1'b1;
    cycle("idle_snooze", 1'b0, 1'b0, 3'd0);
    stop = 1'b1;
    cycle("idle_stop", 1'b0, 1'b0, 3'd0);

    // Alarm time setting and wrap
    for (int i = 0; i < 59; i++) begin
      set_minute = 1'b1;
      cycle("set_min", 1'b0, 1'b0, 3'd0);
    end
    check("min_59", {26'd0, alarm_minute}, 32'd59);
    set_minute = 1'b1;
    cycle("set_min_wrap", 1'b0, 1'b0, 3'd0);
    check("min_wrap", {26'd0, alarm_minute}, 32'd0);
    check("min_wrap_hour", {27'd0, alarm_hour}, 32'd7);
    for (int i = 0; i < 16; i++) begin
      set_hour = 1'b1;
      cycle("set_hour", 1'b0, 1'b0, 3'd0);
    end
    check("hour_23", {27'd0, alarm_hour}, 32'd23);
    set_hour = 1'b1;
    set_minute = 1'b1;
    cycle("set_both", 1'b0, 1'b0, 3'd0);
    check("hour_wrap", {27'd0, alarm_hour}, 32'd0);
    check("both_min", {26'd0, alarm_minute}, 32'd1);
    do_reset();

    // Stop and snooze same clock in RING; stop wins
    trigger();
    stop = 1'b1;
    snooze = 1'b1;
    cycle("stop_over_snooze", 1'b0, 1'b0, 3'd0);

    // Disarm during SNOOZE
    trigger();
    snooze = 1'b1;
    cycle("snooze_again", 1'b0, 1'b1, 3'd1);
    tick_n(3, "snz_wait2", 1'b0, 1'b1, 3'd1);
    alarm_arm = 1'b0;
    cycle("disarm_snz", 1'b0, 1'b0, 3'd0);
    alarm_arm = 1'b1;

    // Stop during SNOOZE
    trigger();
    snooze = 1'b1;
    cycle("snooze_3", 1'b0, 1'b1, 3'd1);
    stop = 1'b1;
    cycle("stop_snz", 1'b0, 1'b0, 3'd0);

    // Disarmed at alarm time: no ring
    alarm_arm = 1'b0;
    set_time(7, 0, 0);
    tick_1s = 1'b1;
    cycle("disarmed_match", 1'b0, 1'b0, 3'd0);
    alarm_arm = 1'b1;

    // Reset mid-RING aborts asynchronously
    trigger();
    tick_n(2, "ring_pre_rst", 1'b1, 1'b0, 3'd0);
    do_reset();
    tick_n(5, "post_rst_idle", 1'b0, 1'b0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
